// File: rtl/jtbubl_rom_pkg.sv
// Shared definitions for the graphics ROM slot: FSM encoding and default widths.
package jtbubl_rom_pkg;

   localparam int unsigned ROM_AW   = 18;
   localparam int unsigned SDRAM_AW = 22;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } state_e;

endpackage

// File: rtl/jtbubl_rom_tag.sv
// Tag cache for the ROM slot: entry storage, hit compare and registered rom_ok/rom_data.
// JTBUBL_ROMSLOT_CACHE2_EN selects a two-entry cache with an LRU bit instead of one entry.
module jtbubl_rom_tag #(
   parameter int unsigned TW = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lookup_en,
   input  logic [TW-1:0] lookup_tag,
   input  logic          fill,
   input  logic [TW-1:0] fill_tag,
   input  logic [31:0]   fill_data,
   output logic          hit,
   output logic          ok,
   output logic [31:0]   rd_data
);

`ifdef JTBUBL_ROMSLOT_CACHE2_EN

   logic [1:0]    valid_q;
   logic [TW-1:0] tag_q [2];
   logic [31:0]   data_q [2];
   logic          lru_q;
   logic          ok_q;
   logic [31:0]   rd_q;
   logic [1:0]    match;
   logic [31:0]   hit_data;

   assign match[0] = valid_q[0] && (tag_q[0] == lookup_tag);
   assign match[1] = valid_q[1] && (tag_q[1] == lookup_tag);
   assign hit      = |match;
   assign hit_data = match[1] ? data_q[1] : data_q[0];

   // lru_q names the entry the next fill will replace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= '0;
         tag_q[0]  <= '0;
         tag_q[1]  <= '0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         lru_q     <= 1'b0;
         ok_q      <= 1'b0;
         rd_q      <= '0;
      end else begin
         ok_q <= lookup_en && hit;
         if (lookup_en && hit) begin
            rd_q <= hit_data;
         end
         if (fill) begin
            valid_q[lru_q] <= 1'b1;
            tag_q[lru_q]   <= fill_tag;
            data_q[lru_q]  <= fill_data;
            lru_q          <= ~lru_q;
         end else if (lookup_en && hit) begin
            lru_q <= ~match[1];
         end
      end
   end

   assign ok      = ok_q;
   assign rd_data = rd_q;

`else

   logic          valid_q;
   logic [TW-1:0] tag_q;
   logic [31:0]   data_q;
   logic          ok_q;

   assign hit = valid_q && (tag_q == lookup_tag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
         ok_q    <= 1'b0;
      end else begin
         ok_q <= lookup_en && hit;
         if (fill) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            data_q  <= fill_data;
         end
      end
   end

   assign ok      = ok_q;
   assign rd_data = data_q;

`endif

endmodule

// File: rtl/jtbubl_rom_slot.sv
// Graphics ROM slot: turns client 32-bit fetches into SDRAM reads through a small tag cache.
// Optional two-entry cache is enabled by defining JTBUBL_ROMSLOT_CACHE2_EN.
module jtbubl_rom_slot #(
   parameter int unsigned         AW       = jtbubl_rom_pkg::ROM_AW,
   parameter int unsigned         SDRAM_AW = jtbubl_rom_pkg::SDRAM_AW,
   parameter logic [SDRAM_AW-1:0] OFFSET   = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rom_cs,
   input  logic [AW-1:0]       rom_addr,
   output logic [31:0]         rom_data,
   output logic                rom_ok,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [31:0]         data_read
);

   import jtbubl_rom_pkg::state_e;
   import jtbubl_rom_pkg::StIdle;
   import jtbubl_rom_pkg::StReq;
   import jtbubl_rom_pkg::StWait;

   localparam int unsigned TW = AW - 1;

   state_e              state_q, state_d;
   logic [TW-1:0]       req_tag_q, req_tag_d;
   logic                sdram_req_q, sdram_req_d;
   logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;
   logic [TW-1:0]       cur_tag;
   logic [SDRAM_AW-1:0] word_addr;
   logic [SDRAM_AW-1:0] req_addr;
   logic                hit;
   logic                fill;
   logic                unused_addr_lsb;

   // 32-bit fetches always start on an even 16-bit word.
   assign cur_tag         = rom_addr[AW-1:1];
   assign unused_addr_lsb = rom_addr[0];
   assign word_addr       = SDRAM_AW'({rom_addr[AW-1:1], 1'b0});
   assign req_addr        = OFFSET + word_addr;

   jtbubl_rom_tag #(
      .TW(TW)
   ) u_tag (
      .clk       (clk),
      .rst_n     (rst_n),
      .lookup_en (rom_cs),
      .lookup_tag(cur_tag),
      .fill      (fill),
      .fill_tag  (req_tag_q),
      .fill_data (data_read),
      .hit       (hit),
      .ok        (rom_ok),
      .rd_data   (rom_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         req_tag_q    <= '0;
         sdram_req_q  <= 1'b0;
         sdram_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         req_tag_q    <= req_tag_d;
         sdram_req_q  <= sdram_req_d;
         sdram_addr_q <= sdram_addr_d;
      end
   end

   // An issued read always runs to completion: the arbiter has no abort.
   always_comb begin
      state_d      = state_q;
      req_tag_d    = req_tag_q;
      sdram_req_d  = sdram_req_q;
      sdram_addr_d = sdram_addr_q;
      fill         = 1'b0;
      case (state_q)
         StIdle: begin
            if (rom_cs && !hit) begin
               req_tag_d    = cur_tag;
               sdram_addr_d = req_addr;
               sdram_req_d  = 1'b1;
               state_d      = StReq;
            end
         end
         StReq: begin
            if (sdram_ack) begin
               sdram_req_d = 1'b0;
               if (data_rdy) begin
                  fill    = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (data_rdy) begin
               fill    = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign sdram_req  = sdram_req_q;
   assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtbubl_rom_slot.sv
// Directed bench for jtbubl_rom_slot; a second instance exercises the OFFSET wrap.
module tb_jtbubl_rom_slot;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        rom_cs, rom_cs2;
   logic [17:0] rom_addr, rom_addr2;
   logic [31:0] rom_data, rom_data2;
   logic        rom_ok, rom_ok2;
   logic        sdram_req, sdram_req2;
   logic [21:0] sdram_addr, sdram_addr2;
   logic        sdram_ack, data_rdy;
   logic [31:0] data_read;
   logic        zero_ack = 1'b0;
   logic        zero_rdy = 1'b0;
   logic [31:0] zero_data = '0;

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned nreq   = 0;

`ifdef JTBUBL_ROMSLOT_CACHE2_EN
   localparam bit C2 = 1'b1;
`else
   localparam bit C2 = 1'b0;
`endif

   always #5 clk = ~clk;

   jtbubl_rom_slot u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rom_cs    (rom_cs),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rom_ok    (rom_ok),
      .sdram_req (sdram_req),
      .sdram_addr(sdram_addr),
      .sdram_ack (sdram_ack),
      .data_rdy  (data_rdy),
      .data_read (data_read)
   );

   jtbubl_rom_slot #(
      .OFFSET(22'h3FFF00)
   ) u_wrap (
      .clk       (clk),
      .rst_n     (rst_n),
      .rom_cs    (rom_cs2),
      .rom_addr  (rom_addr2),
      .rom_data  (rom_data2),
      .rom_ok    (rom_ok2),
      .sdram_req (sdram_req2),
      .sdram_addr(sdram_addr2),
      .sdram_ack (zero_ack),
      .data_rdy  (zero_rdy),
      .data_read (zero_data)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Present an address; if it misses, serve the read with ack and data together.
   task automatic fetch(input logic [17:0] a, input logic [31:0] d);
      rom_addr = a;
      tick();
      if (sdram_req) begin
         nreq++;
         sdram_ack = 1'b1;
         data_rdy  = 1'b1;
         data_read = d;
         tick();
         sdram_ack = 1'b0;
         data_rdy  = 1'b0;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rom_cs = 0; rom_addr = '0; rom_cs2 = 0; rom_addr2 = '0;
      sdram_ack = 0; data_rdy = 0; data_read = '0;
      #2 rst_n = 1'b0;
      tick(); tick();
      chk("rst_ok", rom_ok, 0);
      chk("rst_data", rom_data, 0);
      chk("rst_req", sdram_req, 0);
      chk("rst_addr", sdram_addr, 0);
      rst_n = 1'b1;
      tick();

      // First miss, ack two cycles after req, data three cycles after ack
      rom_cs = 1; rom_addr = 18'h00100; rom_cs2 = 1; rom_addr2 = 18'h00100;
      tick();
      chk("miss_req", sdram_req, 1);
      chk("miss_addr", sdram_addr, 22'h000100);
      chk("wrap_req", sdram_req2, 1);
      chk("wrap_addr", sdram_addr2, 22'h000000);
      rom_addr2 = 18'h00200;
      tick();
      chk("req_hold", sdram_req, 1);
      chk("wrap_hold_addr", sdram_addr2, 22'h000000);
      chk("wrap_hold_req", sdram_req2, 1);
      sdram_ack = 1;
      tick();
      sdram_ack = 0;
      chk("req_drop", sdram_req, 0);
      tick(); tick();
      data_rdy = 1; data_read = 32'hDEADBEEF;
      tick();
      data_rdy = 0; data_read = '0;
      chk("ok_fill_edge", rom_ok, 0);
      tick();
      chk("ok_after_fill", rom_ok, 1);
      chk("data_after_fill", rom_data, 32'hDEADBEEF);

      // Same tag, odd word
      rom_addr = 18'h00101;
      tick();
      chk("same_tag_ok", rom_ok, 1);
      chk("same_tag_noreq", sdram_req, 0);
      chk("same_tag_data", rom_data, 32'hDEADBEEF);

      // Address change during WAIT
      rom_addr = 18'h00300;
      tick();
      chk("mid_req", sdram_req, 1);
      chk("mid_req_addr", sdram_addr, 22'h000300);
      chk("mid_ok_drop", rom_ok, 0);
      sdram_ack = 1;
      tick();
      sdram_ack = 0; rom_addr = 18'h00200;
      tick();
      chk("mid_wait_ok", rom_ok, 0);
      data_rdy = 1; data_read = 32'h11111111;
      tick();
      data_rdy = 0;
      chk("mid_fill_noreq", sdram_req, 0);
      chk("mid_fill_ok", rom_ok, 0);
      tick();
      chk("reissue_req", sdram_req, 1);
      chk("reissue_addr", sdram_addr, 22'h000200);
      chk("reissue_ok", rom_ok, 0);

      // Ack and data in the same cycle
      sdram_ack = 1; data_rdy = 1; data_read = 32'hCAFEF00D;
      tick();
      sdram_ack = 0; data_rdy = 0;
      chk("ackdata_req", sdram_req, 0);
      tick();
      chk("ackdata_ok", rom_ok, 1);
      chk("ackdata_data", rom_data, 32'hCAFEF00D);

      // rom_cs low, then stray data_rdy in IDLE
      rom_cs = 0;
      tick();
      chk("cs_low_ok", rom_ok, 0);
      chk("cs_low_hold", rom_data, 32'hCAFEF00D);
      data_rdy = 1; data_read = 32'h0BADBAD0;
      tick();
      data_rdy = 0; rom_cs = 1;
      tick();
      chk("stray_rdy_ok", rom_ok, 1);
      chk("stray_rdy_data", rom_data, 32'hCAFEF00D);

      // Reset during WAIT
      rom_addr = 18'h00400;
      tick();
      chk("pre_rst_req", sdram_req, 1);
      sdram_ack = 1;
      tick();
      sdram_ack = 0; rom_cs = 0; rst_n = 0;
      #1;
      chk("async_rst_req", sdram_req, 0);
      chk("async_rst_addr", sdram_addr, 0);
      chk("async_rst_data", rom_data, 0);
      tick();
      rst_n = 1;
      tick();
      data_rdy = 1; data_read = 32'h55555555;
      tick();
      data_rdy = 0;
      chk("post_rst_ok", rom_ok, 0);
      chk("post_rst_data", rom_data, 0);
      chk("post_rst_req", sdram_req, 0);
      rom_cs = 1; rom_addr = 18'h00200;
      tick();
      chk("invalid_miss_req", sdram_req, 1);
      chk("invalid_miss_ok", rom_ok, 0);
      sdram_ack = 1; data_rdy = 1; data_read = 32'h0000000A;
      tick();
      sdram_ack = 0; data_rdy = 0;
      tick();
      chk("refill_ok", rom_ok, 1);

      // A, B, A: second A hits only with the two-entry cache
      nreq = 0;
      fetch(18'h00010, 32'hAAAA0001);
      chk("a_ok", rom_ok, 1);
      chk("a_data", rom_data, 32'hAAAA0001);
      fetch(18'h00020, 32'hBBBB0002);
      chk("b_ok", rom_ok, 1);
      chk("b_data", rom_data, 32'hBBBB0002);
      rom_addr = 18'h00010;
      tick();
      chk("a2_ok", rom_ok, C2 ? 1 : 0);
      chk("a2_req", sdram_req, C2 ? 0 : 1);
      if (sdram_req) begin
         nreq++;
         sdram_ack = 1; data_rdy = 1; data_read = 32'hAAAA0001;
         tick();
         sdram_ack = 0; data_rdy = 0;
         tick();
      end
      chk("req_count", nreq, C2 ? 2 : 3);
      chk("a2_data", rom_data, 32'hAAAA0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
